// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and helpers for the memory-port arbiter:
//   - arb_state_t   : arbiter FSM states (IDLE / OWN / DRAIN)
//   - req_id_width  : requester-id width, $clog2(n) but never below 1
//   - addr_slice /
//     data_slice    : pick requester idx's field out of a packed bus
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_t;

   // Widest packed bus / single field the slice helpers accept.
   localparam int unsigned PACKED_MAX = 4096;
   localparam int unsigned SLICE_MAX  = 256;

   function automatic int unsigned req_id_width(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Callers truncate the result to their own field width.
   function automatic logic [SLICE_MAX-1:0] addr_slice(input logic [PACKED_MAX-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned width);
      return SLICE_MAX'(bus >> (idx * width));
   endfunction

   function automatic logic [SLICE_MAX-1:0] data_slice(input logic [PACKED_MAX-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned width);
      return SLICE_MAX'(bus >> (idx * width));
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Requester/memory-side bundle of the memory-port arbiter.
//   Requester side : in_req, in_read_en, in_write_en, in_address, in_data
//   Memory side    : out_mem_address, out_mem_data, out_mem_read_en, out_mem_write_en
//   Status         : out_grant, out_rdata_valid, out_busy
//   Modports: master (requesters + memory model), slave (arbiter).
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 96
);
   logic [NUM_REQ-1:0]            in_req;
   logic [NUM_REQ-1:0]            in_read_en;
   logic [NUM_REQ-1:0]            in_write_en;
   logic [NUM_REQ*ADDR_WIDTH-1:0] in_address;
   logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
   logic [NUM_REQ-1:0]            out_grant;
   logic [ADDR_WIDTH-1:0]         out_mem_address;
   logic [DATA_WIDTH-1:0]         out_mem_data;
   logic                          out_mem_read_en;
   logic                          out_mem_write_en;
   logic [NUM_REQ-1:0]            out_rdata_valid;
   logic                          out_busy;

   modport master (
      output in_req, in_read_en, in_write_en, in_address, in_data,
      input  out_grant, out_mem_address, out_mem_data, out_mem_read_en,
             out_mem_write_en, out_rdata_valid, out_busy
   );

   modport slave (
      input  in_req, in_read_en, in_write_en, in_address, in_data,
      output out_grant, out_mem_address, out_mem_data, out_mem_read_en,
             out_mem_write_en, out_rdata_valid, out_busy
   );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// mem_port_arbiter_rr_pick
//   Combinational rotating-priority picker: first set bit of req at or
//   after ptr, wrapping around.
//   req    : request vector
//   ptr    : highest-priority requester index
//   onehot : selected requester (one-hot, zero when nothing requested)
//   id     : selected requester index
//   found  : some request was selected
module mem_port_arbiter_rr_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]  onehot,
   output logic [ID_WIDTH-1:0] id,
   output logic                found
);
   logic [ID_WIDTH-1:0] idx;

   always_comb begin
      onehot = '0;
      id     = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = ID_WIDTH'((32'(ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            onehot[idx] = 1'b1;
            id          = idx;
            found       = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port among NUM_REQ requesters. Rotating priority,
//   bounded hold time (MAX_HOLD), owner-only muxing onto the memory, and
//   read-valid strobes routed back to the issuing requester READ_LATENCY
//   cycles after the read. Outstanding reads drain before re-arbitration.
//   in_clk   : clock, rising edge
//   in_reset : synchronous active-high reset
//   bus      : slave side of mem_port_arbiter_if (requests, strobes,
//              packed address/data in; grant, memory port, valids, busy out)
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 96,
   parameter int MAX_HOLD     = 16,
   parameter int READ_LATENCY = 1
) (
   input logic                in_clk,
   input logic                in_reset,
   mem_port_arbiter_if.slave  bus
);
   localparam int ID_W   = req_id_width(NUM_REQ);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   arb_state_t          state, state_nx;
   logic [NUM_REQ-1:0]  grant, grant_nx;
   logic [ID_W-1:0]     owner, owner_nx;
   logic [ID_W-1:0]     ptr, ptr_nx;
   logic [HOLD_W-1:0]   hold, hold_nx;

   logic [NUM_REQ-1:0]  pick_onehot;
   logic [ID_W-1:0]     pick_id;
   logic                pick_found;

   // Read tracking: stage k holds the read issued k+1 cycles ago.
   logic [READ_LATENCY-1:0] trk_valid;
   logic [ID_W-1:0]         trk_id [READ_LATENCY];

   logic owning;
   logic owner_req;
   logic others_req;

   assign owning     = (state == ST_OWN);
   assign owner_req  = bus.in_req[owner];
   assign others_req = |(bus.in_req & ~grant);

   mem_port_arbiter_rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_W)
   ) u_pick (
      .req    (bus.in_req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .id     (pick_id),
      .found  (pick_found)
   );

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state <= ST_IDLE;
         grant <= '0;
         owner <= '0;
         ptr   <= '0;
         hold  <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         owner <= owner_nx;
         ptr   <= ptr_nx;
         hold  <= hold_nx;
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      owner_nx = owner;
      ptr_nx   = ptr;
      hold_nx  = hold;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               state_nx = ST_OWN;
               grant_nx = pick_onehot;
               owner_nx = pick_id;
               hold_nx  = HOLD_W'(1);
            end
         end
         ST_OWN: begin
            if (!owner_req || (hold == HOLD_W'(MAX_HOLD) && others_req)) begin
               state_nx = ST_DRAIN;
               grant_nx = '0;
               ptr_nx   = (32'(owner) == NUM_REQ - 1) ? '0 : owner + ID_W'(1);
            end else if (hold != HOLD_W'(MAX_HOLD)) begin
               hold_nx = hold + HOLD_W'(1);
            end
         end
         ST_DRAIN: begin
            if (trk_valid == '0) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Memory port: only the owner's lines pass; write beats a same-cycle read.
   always_comb begin
      bus.out_mem_address  = '0;
      bus.out_mem_data     = '0;
      bus.out_mem_read_en  = 1'b0;
      bus.out_mem_write_en = 1'b0;
      if (owning) begin
         bus.out_mem_address  = ADDR_WIDTH'(addr_slice(PACKED_MAX'(bus.in_address), 32'(owner), ADDR_WIDTH));
         bus.out_mem_data     = DATA_WIDTH'(data_slice(PACKED_MAX'(bus.in_data), 32'(owner), DATA_WIDTH));
         bus.out_mem_write_en = bus.in_write_en[owner];
         bus.out_mem_read_en  = bus.in_read_en[owner] & ~bus.in_write_en[owner];
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         trk_valid <= '0;
         for (int unsigned k = 0; k < READ_LATENCY; k++) begin
            trk_id[k] <= '0;
         end
      end else begin
         trk_valid[0] <= bus.out_mem_read_en;
         trk_id[0]    <= owner;
         for (int unsigned k = 1; k < READ_LATENCY; k++) begin
            trk_valid[k] <= trk_valid[k-1];
            trk_id[k]    <= trk_id[k-1];
         end
      end
   end

   always_comb begin
      bus.out_rdata_valid = '0;
      if (trk_valid[READ_LATENCY-1]) begin
         bus.out_rdata_valid = NUM_REQ'(1) << trk_id[READ_LATENCY-1];
      end
   end

   assign bus.out_grant = grant;
   assign bus.out_busy  = (state != ST_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port among NUMBER_OF_PROCESSORS processing units. Those units currently drive the memory address, data and enable lines in parallel.
- Grants ownership to one requester at a time using rotating priority, with a bounded hold time.
- Multiplexes only the owner's address, data and enables onto the memory.
- Routes read-data-valid strobes back to the requester that issued the read, and drains outstanding reads before ownership changes.

Parameters:
- NUM_REQ, 4, number of requesters (processors).
- ADDR_WIDTH, 10, memory address width (log2 of memory size).
- DATA_WIDTH, 96, memory data width (block size × word size).
- MAX_HOLD, 16, maximum owned cycles before forced release when others are waiting; must be ≥1.
- READ_LATENCY, 1, cycles from read enable to valid memory read data; must be ≥1.

Ports:
- in_clk  input  1  clock; all state updates on rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_req  input  NUM_REQ  per-requester ownership request (level).
- in_read_en  input  NUM_REQ  per-requester read strobe.
- in_write_en  input  NUM_REQ  per-requester write strobe.
- in_address  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- in_data  input  NUM_REQ*DATA_WIDTH  packed write data; same packing.
- out_grant  output  NUM_REQ  one-hot ownership, registered.
- out_mem_address  output  ADDR_WIDTH  to memory.
- out_mem_data  output  DATA_WIDTH  to memory.
- out_mem_read_en  output  1  to memory.
- out_mem_write_en  output  1  to memory.
- out_rdata_valid  output  NUM_REQ  one-hot; memory read data is valid for requester i.
- out_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high) values:
  - out_grant=0, out_busy=0, out_rdata_valid=0.
  - Memory enables=0; address and data outputs=0.
  - Priority pointer=0, hold counter=0, read-tracking pipeline cleared.
  - Reset mid-operation discards in-flight read tracking; no valid strobe is emitted after reset.
- FSM states: IDLE, OWN, DRAIN.
- IDLE:
  - If any in_req is high at cycle t, select the first requester at or after the pointer, with wrap-around.
  - out_grant is set at t+1; go to OWN.
  - Hold counter is loaded with 1.
- OWN:
  - out_mem_* mirror the owner's inputs combinationally, gated by grant. Non-owner strobes never reach memory.
  - If the owner asserts write and read in the same cycle, the write wins and the read is suppressed (not tracked).
  - The hold counter increments each owned cycle and saturates at MAX_HOLD.
  - Release occurs when the owner deasserts in_req, or when the hold counter equals MAX_HOLD and another in_req is high.
  - If the hold counter reaches MAX_HOLD with no other requester, ownership continues.
  - On release: out_grant goes to 0 next cycle; pointer = owner+1 mod NUM_REQ; go to DRAIN.
- DRAIN:
  - No memory enables are driven.
  - Wait until the read-tracking pipeline is empty, then go to IDLE.
  - Re-arbitration happens from IDLE, so there is a minimum of one idle cycle between owners.
- Read tracking:
  - A shift register of depth READ_LATENCY carries {valid, owner id}.
  - out_rdata_valid[id] is asserted exactly READ_LATENCY cycles after out_mem_read_en.
- Back-to-back reads: one per cycle is supported, and a strobe is returned every cycle.
- Requester dropping in_req while reads are outstanding: its valid strobes are still delivered during DRAIN.
- out_grant is always one-hot or zero (assertion in the bench).

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/OWN/DRAIN).
  - Requester-id width constant, $clog2(NUM_REQ) with a minimum of 1.
  - Slice-extraction helper functions for the packed address and data buses.
- Sub-module: rr_pick. Combinational rotating-priority picker taking the request vector and pointer, returning a one-hot vector and an id.
- Read tracking stays inline.

Test Plan:
- Reset then single requester: in_req=4'b0010 at cycle 3 → out_grant=4'b0010 at cycle 4, out_busy=1; read at address 10'h005 → out_mem_address=10'h005, out_rdata_valid=4'b0010 at the next cycle (READ_LATENCY=1).
- All four request continuously, MAX_HOLD=4 → grants rotate 0001→0010→0100→1000→0001, each held exactly 4 cycles, one DRAIN and one IDLE gap between owners, no overlap.
- Sole requester 2, MAX_HOLD=4, holds 10 cycles → grant stays 4'b0100 for all 10 cycles; releases on in_req drop; pointer becomes 3.
- Owner issues reads on its last 2 cycles then drops in_req, READ_LATENCY=3 → both out_rdata_valid strobes go to that owner during DRAIN; next grant appears only after the pipeline empties.
- Non-owner asserts write_en=1 with data 96'hA5… while requester 0 owns → out_mem_write_en reflects only requester 0; memory never sees A5… data.
- Owner asserts read and write together → out_mem_write_en=1, out_mem_read_en=0, no valid strobe; in_reset asserted mid-OWN with a read in flight → all outputs 0 next cycle, no late valid.
